// File: rtl/axi_lite_aw_channel.sv
// AXI4-Lite write-address channel pair.
// The master half turns a level user request into a single AW transfer.
// The slave half drives a registered AWREADY and captures the accepted
// address and protection bits on every handshake.
module axi_lite_aw_channel (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        i_AWVALID,
  input  logic [31:0] i_AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        i_AWREADY,
  output logic        o_AWVALID,
  output logic [31:0] o_AWADDR,
  output logic [2:0]  o_AWPROT,
  output logic        o_AWREADY,
  output logic [31:0] o_cap_addr,
  output logic [2:0]  o_cap_prot,
  output logic        o_aw_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  logic [0:0]  state_r;
  logic [0:0]  state_nxt_s;
  logic        aw_valid_r;
  logic        aw_valid_nxt_s;
  logic [31:0] aw_addr_r;
  logic [31:0] aw_addr_nxt_s;
  logic [2:0]  aw_prot_r;
  logic [2:0]  aw_prot_nxt_s;
  logic        aw_ready_r;
  logic [31:0] cap_addr_r;
  logic [2:0]  cap_prot_r;
  logic        aw_done_r;
  logic        handshake_s;

  // Handshake uses only registered VALID and READY, so VALID never depends
  // combinationally on READY.
  assign handshake_s = aw_valid_r & aw_ready_r;

  // Master next-state: latch the request in IDLE, hold it stable in VALID
  // until the handshake. A dropped request does not withdraw VALID.
  always_comb begin
    state_nxt_s    = state_r;
    aw_valid_nxt_s = aw_valid_r;
    aw_addr_nxt_s  = aw_addr_r;
    aw_prot_nxt_s  = aw_prot_r;
    case (state_r)
      ST_IDLE: begin
        if (i_AWVALID) begin
          state_nxt_s    = ST_VALID;
          aw_valid_nxt_s = 1'b1;
          aw_addr_nxt_s  = i_AWADDR;
          aw_prot_nxt_s  = AWPROT;
        end else begin
          state_nxt_s    = ST_IDLE;
          aw_valid_nxt_s = 1'b0;
        end
      end
      ST_VALID: begin
        if (handshake_s) begin
          // Always return to IDLE for at least one cycle after a transfer.
          state_nxt_s    = ST_IDLE;
          aw_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = ST_VALID;
          aw_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        aw_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Master state and AW output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r    <= ST_IDLE;
      aw_valid_r <= 1'b0;
      aw_addr_r  <= 32'h0000_0000;
      aw_prot_r  <= 3'b000;
    end else begin
      state_r    <= state_nxt_s;
      aw_valid_r <= aw_valid_nxt_s;
      aw_addr_r  <= aw_addr_nxt_s;
      aw_prot_r  <= aw_prot_nxt_s;
    end
  end

  // Slave READY is a one-edge delayed copy of the accept enable.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_ready_r <= 1'b0;
    end else begin
      aw_ready_r <= i_AWREADY;
    end
  end

  // Slave capture: record address/prot on a handshake, hold otherwise,
  // and pulse done for the cycle following the handshake edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cap_addr_r <= 32'h0000_0000;
      cap_prot_r <= 3'b000;
      aw_done_r  <= 1'b0;
    end else begin
      if (handshake_s) begin
        cap_addr_r <= aw_addr_r;
        cap_prot_r <= aw_prot_r;
      end
      aw_done_r <= handshake_s;
    end
  end

  assign o_AWVALID  = aw_valid_r;
  assign o_AWADDR   = aw_addr_r;
  assign o_AWPROT   = aw_prot_r;
  assign o_AWREADY  = aw_ready_r;
  assign o_cap_addr = cap_addr_r;
  assign o_cap_prot = cap_prot_r;
  assign o_aw_done  = aw_done_r;

endmodule

// File: tb/tb_axi_lite_aw_channel.sv
// Directed self-checking bench for axi_lite_aw_channel.
module tb_axi_lite_aw_channel;

  logic        ACLK;
  logic        ARESETn;
  logic        i_AWVALID;
  logic [31:0] i_AWADDR;
  logic [2:0]  AWPROT;
  logic        i_AWREADY;
  logic        o_AWVALID;
  logic [31:0] o_AWADDR;
  logic [2:0]  o_AWPROT;
  logic        o_AWREADY;
  logic [31:0] o_cap_addr;
  logic [2:0]  o_cap_prot;
  logic        o_aw_done;

  int checks;
  int errors;

  axi_lite_aw_channel dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .i_AWVALID  (i_AWVALID),
    .i_AWADDR   (i_AWADDR),
    .AWPROT     (AWPROT),
    .i_AWREADY  (i_AWREADY),
    .o_AWVALID  (o_AWVALID),
    .o_AWADDR   (o_AWADDR),
    .o_AWPROT   (o_AWPROT),
    .o_AWREADY  (o_AWREADY),
    .o_cap_addr (o_cap_addr),
    .o_cap_prot (o_cap_prot),
    .o_aw_done  (o_aw_done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; sampling and driving happen 1 time unit later.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, o_AWVALID}, 32'd0);
    chk({tag, "_addr"},  o_AWADDR, 32'd0);
    chk({tag, "_prot"},  {29'd0, o_AWPROT}, 32'd0);
    chk({tag, "_ready"}, {31'd0, o_AWREADY}, 32'd0);
    chk({tag, "_caddr"}, o_cap_addr, 32'd0);
    chk({tag, "_cprot"}, {29'd0, o_cap_prot}, 32'd0);
    chk({tag, "_done"},  {31'd0, o_aw_done}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ARESETn   = 1'b0;
    i_AWVALID = 1'b1;
    i_AWADDR  = 32'hFFFF_FFFF;
    AWPROT    = 3'b010;
    i_AWREADY = 1'b0;

    // Reset held with an active request: everything stays zero.
    #2;
    chk_all_zero("rst0");
    tick();
    tick();
    chk_all_zero("rst_hold");

    // Release: first edge latches the request.
    ARESETn = 1'b1;
    tick();
    chk("rel_valid", {31'd0, o_AWVALID}, 32'd1);
    chk("rel_addr", o_AWADDR, 32'hFFFF_FFFF);
    chk("rel_prot", {29'd0, o_AWPROT}, 32'd2);

    // Stall with READY low for several cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, o_AWVALID}, 32'd1);
      chk("stall_addr", o_AWADDR, 32'hFFFF_FFFF);
      chk("stall_done", {31'd0, o_aw_done}, 32'd0);
    end

    // Input address changes while stalled: output must not follow.
    i_AWADDR = 32'h1234_5678;
    tick();
    chk("stab_addr", o_AWADDR, 32'hFFFF_FFFF);
    chk("stab_prot", {29'd0, o_AWPROT}, 32'd2);

    // Accept: READY appears one edge later, then handshake.
    i_AWREADY = 1'b1;
    tick();
    chk("acc_ready", {31'd0, o_AWREADY}, 32'd1);
    chk("acc_valid", {31'd0, o_AWVALID}, 32'd1);
    chk("acc_addr", o_AWADDR, 32'hFFFF_FFFF);
    chk("acc_done0", {31'd0, o_aw_done}, 32'd0);
    tick();
    chk("hs1_caddr", o_cap_addr, 32'hFFFF_FFFF);
    chk("hs1_cprot", {29'd0, o_cap_prot}, 32'd2);
    chk("hs1_done", {31'd0, o_aw_done}, 32'd1);
    chk("hs1_valid", {31'd0, o_AWVALID}, 32'd0);

    // Streaming: request held, one transfer every two cycles.
    tick();
    chk("s0_done", {31'd0, o_aw_done}, 32'd0);
    chk("s0_valid", {31'd0, o_AWVALID}, 32'd1);
    chk("s0_addr", o_AWADDR, 32'h1234_5678);
    chk("s0_caddr", o_cap_addr, 32'hFFFF_FFFF);
    i_AWADDR = 32'h0000_0010;
    AWPROT   = 3'b001;
    tick();
    chk("s1_done", {31'd0, o_aw_done}, 32'd1);
    chk("s1_caddr", o_cap_addr, 32'h1234_5678);
    chk("s1_valid", {31'd0, o_AWVALID}, 32'd0);
    tick();
    chk("s2_done", {31'd0, o_aw_done}, 32'd0);
    chk("s2_addr", o_AWADDR, 32'h0000_0010);
    i_AWADDR = 32'h0000_0020;
    AWPROT   = 3'b011;
    tick();
    chk("s3_done", {31'd0, o_aw_done}, 32'd1);
    chk("s3_caddr", o_cap_addr, 32'h0000_0010);
    chk("s3_cprot", {29'd0, o_cap_prot}, 32'd1);
    tick();
    chk("s4_done", {31'd0, o_aw_done}, 32'd0);
    chk("s4_addr", o_AWADDR, 32'h0000_0020);
    i_AWVALID = 1'b0;
    tick();
    chk("s5_done", {31'd0, o_aw_done}, 32'd1);
    chk("s5_caddr", o_cap_addr, 32'h0000_0020);
    chk("s5_cprot", {29'd0, o_cap_prot}, 32'd3);
    tick();
    chk("idle_valid", {31'd0, o_AWVALID}, 32'd0);
    chk("idle_done", {31'd0, o_aw_done}, 32'd0);
    chk("idle_caddr", o_cap_addr, 32'h0000_0020);

    // Dropped request does not withdraw VALID.
    i_AWREADY = 1'b0;
    i_AWVALID = 1'b1;
    i_AWADDR  = 32'hAAAA_0000;
    AWPROT    = 3'b100;
    tick();
    chk("drop_valid0", {31'd0, o_AWVALID}, 32'd1);
    chk("drop_ready0", {31'd0, o_AWREADY}, 32'd0);
    i_AWVALID = 1'b0;
    tick();
    chk("drop_valid1", {31'd0, o_AWVALID}, 32'd1);
    chk("drop_addr", o_AWADDR, 32'hAAAA_0000);

    // READY falls on the handshake edge: handshake still completes.
    i_AWREADY = 1'b1;
    tick();
    chk("sim_ready", {31'd0, o_AWREADY}, 32'd1);
    chk("sim_done0", {31'd0, o_aw_done}, 32'd0);
    i_AWREADY = 1'b0;
    tick();
    chk("sim_done", {31'd0, o_aw_done}, 32'd1);
    chk("sim_caddr", o_cap_addr, 32'hAAAA_0000);
    chk("sim_cprot", {29'd0, o_cap_prot}, 32'd4);
    chk("sim_ready1", {31'd0, o_AWREADY}, 32'd0);
    chk("sim_valid", {31'd0, o_AWVALID}, 32'd0);

    // Reset mid-transfer: immediate zeros, no capture, no done.
    i_AWVALID = 1'b1;
    i_AWADDR  = 32'h5555_5555;
    AWPROT    = 3'b111;
    i_AWREADY = 1'b1;
    tick();
    chk("mid_valid", {31'd0, o_AWVALID}, 32'd1);
    ARESETn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    chk_all_zero("mid_hold");

    // After release the first edge with a request starts a fresh transfer.
    ARESETn = 1'b1;
    tick();
    chk("fresh_valid", {31'd0, o_AWVALID}, 32'd1);
    chk("fresh_addr", o_AWADDR, 32'h5555_5555);
    chk("fresh_ready", {31'd0, o_AWREADY}, 32'd1);
    chk("fresh_done0", {31'd0, o_aw_done}, 32'd0);
    i_AWVALID = 1'b0;
    tick();
    chk("fresh_done", {31'd0, o_aw_done}, 32'd1);
    chk("fresh_caddr", o_cap_addr, 32'h5555_5555);
    chk("fresh_cprot", {29'd0, o_cap_prot}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
